// File: rtl/csr_exec_rs_if.sv
// Dispatch, CDB, CSR-file and write-back signals of the CSR reservation station.
// master = dispatcher/CDB/consumer side, slave = csr_exec_rs.
interface csr_exec_rs_if #(
   parameter int TAG_W = 6
) ();
   logic             disp_valid;
   logic             disp_ready;
   logic [1:0]       disp_op;
   logic [11:0]      disp_csr_addr;
   logic [31:0]      disp_old_csr;
   logic             disp_src_ready;
   logic [TAG_W-1:0] disp_src_tag;
   logic [31:0]      disp_src_val;
   logic [TAG_W-1:0] disp_rd_tag;

   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_data;

   logic             CSR_done;
   logic [31:0]      CSR_Result;
   logic [11:0]      RS_CSR_Address;

   logic             wb_valid;
   logic [TAG_W-1:0] wb_tag;
   logic [31:0]      wb_data;

   modport master (
      output disp_valid, disp_op, disp_csr_addr, disp_old_csr,
             disp_src_ready, disp_src_tag, disp_src_val, disp_rd_tag,
             cdb_valid, cdb_tag, cdb_data,
      input  disp_ready, CSR_done, CSR_Result, RS_CSR_Address,
             wb_valid, wb_tag, wb_data
   );

   modport slave (
      input  disp_valid, disp_op, disp_csr_addr, disp_old_csr,
             disp_src_ready, disp_src_tag, disp_src_val, disp_rd_tag,
             cdb_valid, cdb_tag, cdb_data,
      output disp_ready, CSR_done, CSR_Result, RS_CSR_Address,
             wb_valid, wb_tag, wb_data
   );
endinterface

// File: rtl/csr_exec_rs.sv
// In-order CSR reservation station + execute stage feeding the CSR register file.
// Define CSR_RS_CDB_BYPASS_EN to capture a same-cycle CDB broadcast at dispatch instead of stalling.
module csr_exec_rs #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   csr_exec_rs_if.slave bus
);
   localparam int             PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [1:0]     OP_RS    = 2'b10;
   localparam logic [1:0]     OP_RC    = 2'b11;

   typedef struct packed {
      logic [1:0]       op;
      logic [11:0]      csr_addr;
      logic [31:0]      old_csr;
      logic             src_rdy;
      logic [TAG_W-1:0] src_tag;
      logic [31:0]      src_val;
      logic [TAG_W-1:0] rd_tag;
   } entry_t;

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;
   logic             r_csr_done;
   logic [31:0]      r_csr_result;
   logic [11:0]      r_csr_addr;
   logic             r_wb_valid;
   logic [TAG_W-1:0] r_wb_tag;
   logic [31:0]      r_wb_data;

   logic [DEPTH-1:0] w_valid;
   logic [DEPTH-1:0] w_wake;
   logic             w_addr_hazard;
   logic             w_cdb_hit_disp;
   logic             w_disp_ready;
   logic             w_disp_fire;
   logic             w_issue;
   entry_t           w_head;
   entry_t           w_new;
   logic [31:0]      w_new_csr;

   // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
   always_comb begin
      logic [PTR_W-1:0] off;
      off           = '0;
      w_valid       = '0;
      w_wake        = '0;
      w_addr_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         off        = PTR_W'(i) - r_head;
         w_valid[i] = ({1'b0, off} < r_count);
         w_wake[i]  = w_valid[i] && !r_mem[i].src_rdy && bus.cdb_valid &&
                      (r_mem[i].src_tag == bus.cdb_tag);
         if (w_valid[i] && (r_mem[i].csr_addr == bus.disp_csr_addr))
            w_addr_hazard = 1'b1;
      end
      // The op sitting in the output stage has not reached the CSR file yet.
      if (r_csr_done && (r_csr_addr == bus.disp_csr_addr))
         w_addr_hazard = 1'b1;
   end

   assign w_cdb_hit_disp = !bus.disp_src_ready && bus.cdb_valid &&
                           (bus.disp_src_tag == bus.cdb_tag);

   always_comb begin
      w_new         = '{op:       bus.disp_op,
                        csr_addr: bus.disp_csr_addr,
                        old_csr:  bus.disp_old_csr,
                        src_rdy:  bus.disp_src_ready,
                        src_tag:  bus.disp_src_tag,
                        src_val:  bus.disp_src_val,
                        rd_tag:   bus.disp_rd_tag};
`ifdef CSR_RS_CDB_BYPASS_EN
      w_disp_ready  = (r_count < CNT_FULL) && !w_addr_hazard;
      if (w_cdb_hit_disp) begin
         w_new.src_rdy = 1'b1;
         w_new.src_val = bus.cdb_data;
      end
`else
      // Without the bypass the broadcast would slip past the new entry, so hold dispatch a cycle.
      w_disp_ready  = (r_count < CNT_FULL) && !w_addr_hazard && !w_cdb_hit_disp;
`endif
   end

   assign w_disp_fire = bus.disp_valid && w_disp_ready;
   assign w_head      = r_mem[r_head];
   assign w_issue     = (r_count != '0) && w_head.src_rdy;

   always_comb begin
      w_new_csr = w_head.src_val;
      case (w_head.op)
         OP_RS:   w_new_csr = w_head.old_csr | w_head.src_val;
         OP_RC:   w_new_csr = w_head.old_csr & ~w_head.src_val;
         default: w_new_csr = w_head.src_val;
      endcase
   end

   // NOTE: the entry array carries no reset; validity comes solely from head/count, which are reset.
   always_ff @(posedge clk) begin
      if (reset && !flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_wake[i]) begin
               r_mem[i].src_rdy <= 1'b1;
               r_mem[i].src_val <= bus.cdb_data;
            end
         end
         if (w_disp_fire)
            r_mem[r_tail] <= w_new;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         r_csr_done   <= 1'b0;
         r_csr_result <= '0;
         r_csr_addr   <= '0;
         r_wb_valid   <= 1'b0;
         r_wb_tag     <= '0;
         r_wb_data    <= '0;
      end else if (flush) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_csr_done <= 1'b0;
         r_wb_valid <= 1'b0;
      end else begin
         if (w_disp_fire)
            r_tail <= r_tail + 1'b1;
         if (w_issue)
            r_head <= r_head + 1'b1;
         case ({w_disp_fire, w_issue})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_csr_done <= w_issue;
         r_wb_valid <= w_issue;
         if (w_issue) begin
            r_csr_result <= w_new_csr;
            r_csr_addr   <= w_head.csr_addr;
            r_wb_tag     <= w_head.rd_tag;
            r_wb_data    <= w_head.old_csr;
         end
      end
   end

   assign bus.disp_ready     = w_disp_ready;
   assign bus.CSR_done       = r_csr_done;
   assign bus.CSR_Result     = r_csr_result;
   assign bus.RS_CSR_Address = r_csr_addr;
   assign bus.wb_valid       = r_wb_valid;
   assign bus.wb_tag         = r_wb_tag;
   assign bus.wb_data        = r_wb_data;
endmodule

// File: doc/csr_exec_rs.md
Name: csr_exec_rs

Overview:
- In-order reservation station plus execute stage for CSR instructions (CSRRW/CSRRS/CSRRC and immediate forms); sits directly upstream of the CSR register file.
- Accepts dispatched ops carrying the old CSR value read at decode, waits for the rs1 operand via CDB wake-up, and computes the new CSR value.
- Drives CSR_done/CSR_Result/RS_CSR_Address into the CSR file and returns the old CSR value to rd on a write-back bus.

Parameters:
DEPTH, 4, number of RS entries (power of 2, >=2)
TAG_W, 6, physical-register/ROB tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
flush  in  1  pipeline flush on exception; kills all entries and the output stage
disp_valid  in  1  dispatch request
disp_ready  out  1  RS can accept this cycle
disp_op  in  2  01=RW, 10=RS(set), 11=RC(clear); 00 illegal, treated as RW
disp_csr_addr  in  12  target CSR address
disp_old_csr  in  32  CSR value read at decode (csr_out)
disp_src_ready  in  1  1 = disp_src_val valid (immediate or ready reg)
disp_src_tag  in  TAG_W  rs1 tag when not ready
disp_src_val  in  32  rs1 value / zero-extended uimm
disp_rd_tag  in  TAG_W  destination tag
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB tag
cdb_data  in  32  CDB value
CSR_done  out  1  one-cycle CSR write strobe
CSR_Result  out  32  new CSR value
RS_CSR_Address  out  12  CSR address being written
wb_valid  out  1  one-cycle rd write-back strobe
wb_tag  out  TAG_W  rd tag
wb_data  out  32  old CSR value

Behaviour:
- Storage: circular buffer, head/tail pointers plus count (0..DEPTH). Entry = {op, csr_addr, old_csr, src_rdy, src_tag, src_val, rd_tag}.
- Reset (reset==0 at posedge): count=0, head=tail=0, CSR_done=0, wb_valid=0, CSR_Result=0, RS_CSR_Address=0, wb_tag=0, wb_data=0.
- Reset and flush outrank every other event in the same cycle.
- disp_ready = (count<DEPTH) && no valid entry and no output-stage op with csr_addr==disp_csr_addr. This RAW stall guarantees disp_old_csr is never stale.
- Dispatch fires on disp_valid && disp_ready: write at tail, tail++ (wraps mod DEPTH), count++.
- Wake-up: each cycle, every valid entry with !src_rdy and src_tag==cdb_tag while cdb_valid captures cdb_data and sets src_rdy.
- Issue (strictly in-order): fires when count>0 && head.src_rdy. head++, count--.
- Result computed combinationally and registered, so CSR_done and wb_valid go high the cycle after issue. Max one issue per cycle; back-to-back issue allowed.
  - RW: new = src
  - RS: new = old | src
  - RC: new = old & ~src
  - wb_data = old_csr
- Outputs are held while strobes are low; strobes last exactly one cycle.
- Dispatch and issue in the same cycle: count unchanged. This is legal even at count==DEPTH only if issue occurs; disp_ready is computed from the pre-issue count, so no dispatch at full.
- flush: count=0, head=tail=0, CSR_done=0, wb_valid=0 next cycle. A CDB broadcast in the same cycle is ignored.
- Empty: no strobes. Full: disp_ready=0.

Optional Feature:
CSR_RS_CDB_BYPASS_EN
- Defined: a dispatch with !disp_src_ready whose disp_src_tag matches cdb_tag while cdb_valid stores the entry with src_rdy=1 and src_val=cdb_data.
- Not defined: disp_ready is additionally forced low in that cycle (stall one cycle). The broadcast is never lost either way.

Test Plan:
- Reset low 2 cycles with disp_valid=1 -> disp_ready still evaluates, no entry written, CSR_done=wb_valid=0, all outputs 0.
- Dispatch RS, addr 0x002, old=0x0000_00F0, src ready 0x0000_000F, rd tag 5 -> the cycle after issue: CSR_done=1, CSR_Result=0x0000_00FF, RS_CSR_Address=0x002, wb_valid=1, wb_tag=5, wb_data=0x0000_00F0.
- Dispatch RC, old=0xFFFF_FFFF, src tag 9 not ready; 3 idle cycles, then CDB tag 9 data 0x0000_FF00 -> no strobe before the CDB cycle; CSR_Result=0xFFFF_00FF two cycles after the CDB.
- Fill DEPTH=4 with distinct addresses 0..3, head blocked on tag 7 -> disp_ready=0. CDB tag 7 -> four consecutive CSR_done pulses in dispatch order, count returns to 0.
- Entry pending on addr 0x001, then dispatch to addr 0x001 -> disp_ready=0 until the first op's CSR_done cycle has passed; a dispatch to addr 0x000 is accepted meanwhile.
- Three entries pending, flush=1 together with a CDB for the head tag -> no CSR_done/wb_valid afterwards, disp_ready=1, count=0. With the macro defined, a same-cycle tag match at dispatch is accepted; without it, disp_ready=0 that cycle.
